alu_pipe: RTL

Parametrised, two-stage pipelined ALU with valid/ready handshakes on both sides, replacing the combinational 32-bit ALU in the datapath. It keeps the existing five operation encodings and adds logical and arithmetic shifts, which fills all eight opcodes. It also produces Z/N/C/V condition flags and absorbs downstream backpressure without dropping or duplicating operations. It sits between operand fetch (register read) and writeback.

---
 rtl/alu_pipe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 holds the accepted operation, S2 holds the registered result and Z/N/C/V flags.
module alu_pipe #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       inst,
    input  logic [WIDTH-1:0] da,
    input  logic [WIDTH-1:0] db,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] res,
                                              input logic c, input logic v);
        return {(res == {WIDTH{1'b0}}), res[WIDTH-1], c, v};
    endfunction

    logic             r_s1_valid;
    logic [2:0]       r_s1_inst;
    logic [WIDTH-1:0] r_s1_da;
    logic [WIDTH-1:0] r_s1_db;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_flags;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_in_hs;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_adv;
    assign in_ready  = !r_s1_valid || w_s2_adv;
    assign w_in_hs   = in_valid && in_ready;
    assign out_valid = r_s2_valid;
    assign out       = r_out;
    assign flags     = r_flags;

    assign w_sh  = r_s1_db[SHW-1:0];
    assign w_add = {1'b0, r_s1_da} + {1'b0, r_s1_db};
    // Subtraction as a + ~b + 1 so the carry-out is the "no borrow" (a >= b) flag.
    assign w_sub = {1'b0, r_s1_da} + {1'b0, ~r_s1_db} + {{WIDTH{1'b0}}, 1'b1};

    // Result and carry/overflow of the operation sitting in S1.
    always_comb begin
        w_res = {WIDTH{1'b0}};
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (r_s1_inst)
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (r_s1_da[WIDTH-1] == r_s1_db[WIDTH-1]) &&
                        (w_add[WIDTH-1] != r_s1_da[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (r_s1_da[WIDTH-1] != r_s1_db[WIDTH-1]) &&
                        (w_sub[WIDTH-1] != r_s1_da[WIDTH-1]);
            end
            OP_AND:  w_res = r_s1_da & r_s1_db;
            OP_OR:   w_res = r_s1_da | r_s1_db;
            OP_XOR:  w_res = r_s1_da ^ r_s1_db;
            OP_SLL:  w_res = r_s1_da << w_sh;
            OP_SRL:  w_res = r_s1_da >> w_sh;
            OP_SRA:  w_res = $unsigned($signed(r_s1_da) >>> w_sh);
            default: w_res = {WIDTH{1'b0}};
        endcase
    end

    // S1: capture operands on input handshake, empty when the op moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_inst  <= 3'b000;
            r_s1_da    <= {WIDTH{1'b0}};
            r_s1_db    <= {WIDTH{1'b0}};
        end else if (w_in_hs) begin
            r_s1_valid <= 1'b1;
            r_s1_inst  <= inst;
            r_s1_da    <= da;
            r_s1_db    <= db;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2: load result when S1 advances; out/flags hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out      <= {WIDTH{1'b0}};
            r_flags    <= 4'b0000;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_out      <= w_res;
            r_flags    <= pack_flags(w_res, w_c, w_v);
        end else if (w_s2_adv) begin
            r_s2_valid <= 1'b0;
        end
    end

endmodule
